// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: 2-flop synchroniser, counter debounce, press/release
// pulses, long-press detection and optional auto-repeat. All outputs are registered.
module btn_conditioner #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES     = 1000,
    parameter int unsigned REPEAT_CYCLES   = 250
) (
    input  logic                CCLK,
    input  logic                RSTN,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_long,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int unsigned CNT_W = $clog2(LONG_CYCLES + REPEAT_CYCLES + 1);

    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LongLast  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LongStart = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] RptLast   = CNT_W'(LONG_CYCLES + REPEAT_CYCLES - 1);

    typedef enum logic {
        StStableLo,
        StStableHi
    } deb_state_e;

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        deb_state_e       state_q, state_d;
        logic [CNT_W-1:0] dcnt_q, dcnt_d;
        logic [CNT_W-1:0] hcnt_q, hcnt_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic             long_q, long_d;
        logic             rpt_q, rpt_d;
        logic             level_cur, level_nxt, differs;

        // Debounce: any cycle where the synchronised input agrees with the level clears the count.
        always_comb begin
            state_d = state_q;
            dcnt_d  = '0;
            differs = sync2_q[c] != (state_q == StStableHi);
            if (differs) begin
                if (dcnt_q == DebLast) begin
                    state_d = (state_q == StStableHi) ? StStableLo : StStableHi;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
        end

        always_comb begin
            level_cur = (state_q == StStableHi);
            level_nxt = (state_d == StStableHi);
            press_d   = level_nxt & ~level_cur;
            rel_d     = level_cur & ~level_nxt;
            hcnt_d    = '0;
            long_d    = 1'b0;
            rpt_d     = 1'b0;
            // Hold count is 0 in the first high cycle; wraps to LONG_CYCLES after each repeat slot.
            if (level_cur && level_nxt) begin
                hcnt_d = (hcnt_q == RptLast) ? LongStart : hcnt_q + CNT_W'(1);
                long_d = (hcnt_q == LongLast);
                rpt_d  = repeat_en[c] && (hcnt_q == RptLast);
            end
        end

        always_ff @(posedge CCLK or negedge RSTN) begin
            if (!RSTN) begin
                state_q <= StStableLo;
                dcnt_q  <= '0;
                hcnt_q  <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                hcnt_q  <= hcnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                rpt_q   <= rpt_d;
            end
        end

        assign btn_level[c]   = level_cur;
        assign btn_press[c]   = press_q;
        assign btn_release[c] = rel_q;
        assign btn_long[c]    = long_q;
        assign btn_repeat[c]  = rpt_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncy stimulus, all checked
// cycle-by-cycle against a history-window / press-age reference model.
module tb_btn_conditioner;

    localparam int CH  = 4;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int RPT = 5;

    logic          CCLK = 1'b0;
    logic          RSTN = 1'b0;
    logic [CH-1:0] btn_raw = '0;
    logic [CH-1:0] repeat_en = '0;
    logic [CH-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

    btn_conditioner #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .CCLK       (CCLK),
        .RSTN       (RSTN),
        .btn_raw    (btn_raw),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .btn_repeat (btn_repeat)
    );

    always #20 CCLK = ~CCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: raw history (for the 2-edge synchroniser delay), window of the last
    // DEB synchronised samples, and press age in cycles.
    logic [CH-1:0] rawq[$];
    logic [CH-1:0] seenq[$];
    logic [CH-1:0] m_lvl, m_press, m_rel, m_long, m_rpt;
    int            age[CH];

    // Event log relative to the last clear_ev().
    int t;
    int ev_press[CH], ev_rel[CH], ev_long[CH], ev_rpt[CH];
    int n_press[CH], n_rel[CH], n_long[CH], n_rpt[CH];

    task automatic check_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string pfx);
        check_vec({pfx, "_level"}, btn_level, m_lvl);
        check_vec({pfx, "_press"}, btn_press, m_press);
        check_vec({pfx, "_release"}, btn_release, m_rel);
        check_vec({pfx, "_long"}, btn_long, m_long);
        check_vec({pfx, "_repeat"}, btn_repeat, m_rpt);
    endtask

    task automatic model_clear();
        rawq.delete();
        seenq.delete();
        m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
        for (int c = 0; c < CH; c++) age[c] = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] seen, tog;
        bit            all_diff;
        rawq.push_front(btn_raw);
        if (rawq.size() > 3) void'(rawq.pop_back());
        seen = (rawq.size() == 3) ? rawq[2] : '0;
        seenq.push_front(seen);
        if (seenq.size() > DEB) void'(seenq.pop_back());
        for (int c = 0; c < CH; c++) begin
            all_diff = (seenq.size() == DEB);
            for (int i = 0; i < seenq.size(); i++)
                if (seenq[i][c] == m_lvl[c]) all_diff = 0;
            tog[c] = all_diff;
        end
        m_press = tog & ~m_lvl;
        m_rel   = tog & m_lvl;
        m_lvl   = m_lvl ^ tog;
        for (int c = 0; c < CH; c++) begin
            if (!m_lvl[c])       age[c] = 0;
            else if (m_press[c]) age[c] = 0;
            else                 age[c] = age[c] + 1;
            m_long[c] = m_lvl[c] && (age[c] == LNG);
            m_rpt[c]  = m_lvl[c] && (age[c] > LNG) && ((age[c] - LNG) % RPT == 0) && repeat_en[c];
        end
    endtask

    task automatic clear_ev();
        t = 0;
        for (int c = 0; c < CH; c++) begin
            ev_press[c] = -1; ev_rel[c] = -1; ev_long[c] = -1; ev_rpt[c] = -1;
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rpt[c] = 0;
        end
    endtask

    task automatic step();
        @(posedge CCLK);
        model_edge();
        #1;
        t++;
        check_outs("cyc");
        for (int c = 0; c < CH; c++) begin
            if (btn_press[c])   begin n_press[c]++; if (ev_press[c] < 0) ev_press[c] = t; end
            if (btn_release[c]) begin n_rel[c]++;   if (ev_rel[c] < 0)   ev_rel[c] = t;   end
            if (btn_long[c])    begin n_long[c]++;  if (ev_long[c] < 0)  ev_long[c] = t;  end
            if (btn_repeat[c])  begin n_rpt[c]++;   if (ev_rpt[c] < 0)   ev_rpt[c] = t;   end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset mid-cycle; outputs must drop at once and stay quiet on release.
    task automatic apply_reset();
        #5;
        RSTN = 1'b0;
        #1;
        model_clear();
        check_outs("rst");
        @(negedge CCLK);
        @(negedge CCLK);
        RSTN = 1'b1;
        #1;
        check_outs("rst_rel");
    endtask

    initial begin
        model_clear();
        clear_ev();

        // Reset with all buttons pressed; release between edges.
        btn_raw = 4'hF;
        #50;
        check_outs("in_rst");
        #60;
        RSTN = 1'b1;
        #1;
        check_outs("rst_rel");
        run(10);
        check_int("rst_press_ch0", ev_press[0], 6);
        check_int("rst_press_ch3", ev_press[3], 6);
        check_int("rst_press_count", n_press[0], 1);

        clear_ev();
        btn_raw = 4'h0;
        run(10);
        check_int("rel_all_ch1", ev_rel[1], 6);

        // Glitches shorter than the debounce window on ch3.
        clear_ev();
        btn_raw[3] = 1'b1; run(3);
        btn_raw[3] = 1'b0; run(2);
        btn_raw[3] = 1'b1; run(3);
        btn_raw[3] = 1'b0; run(8);
        check_int("glitch_press", n_press[3], 0);
        check_int("glitch_release", n_rel[3], 0);
        clear_ev();
        btn_raw[3] = 1'b1; run(10);
        btn_raw[3] = 1'b0; run(10);
        check_int("ch3_press_t", ev_press[3], 6);
        check_int("ch3_press_n", n_press[3], 1);
        check_int("ch3_rel_t", ev_rel[3], 16);
        check_int("ch3_rel_n", n_rel[3], 1);

        // Long press with auto-repeat on ch0.
        clear_ev();
        repeat_en[0] = 1'b1;
        btn_raw[0] = 1'b1; run(60);
        btn_raw[0] = 1'b0; run(10);
        check_int("ch0_long_t", ev_long[0], 26);
        check_int("ch0_long_n", n_long[0], 1);
        check_int("ch0_rpt_first", ev_rpt[0], 31);
        check_int("ch0_rpt_n", n_rpt[0], 7);
        check_int("ch0_rel_t", ev_rel[0], 66);
        check_int("ch0_rel_n", n_rel[0], 1);

        // ch1 without repeat, then enabling repeat mid-hold.
        clear_ev();
        btn_raw[1] = 1'b1; run(60);
        btn_raw[1] = 1'b0; run(10);
        check_int("ch1_norpt_long", n_long[1], 1);
        check_int("ch1_norpt_rpt", n_rpt[1], 0);
        clear_ev();
        btn_raw[1] = 1'b1; run(40);
        repeat_en[1] = 1'b1; run(20);
        btn_raw[1] = 1'b0; run(10);
        check_int("ch1_rpt_first", ev_rpt[1], 41);
        check_int("ch1_rpt_n", n_rpt[1], 5);
        repeat_en[1] = 1'b0;

        // Reset in the middle of a hold on ch2.
        clear_ev();
        btn_raw[2] = 1'b1; run(15);
        apply_reset();
        clear_ev();
        run(40);
        check_int("ch2_fresh_press", ev_press[2], 6);
        check_int("ch2_long_t", ev_long[2], 26);
        check_int("ch2_long_n", n_long[2], 1);
        btn_raw[2] = 1'b0; run(10);

        // Simultaneous press on ch0/ch2, ch2 released early.
        clear_ev();
        btn_raw[0] = 1'b1; btn_raw[2] = 1'b1; run(10);
        btn_raw[2] = 1'b0; run(40);
        btn_raw[0] = 1'b0; run(10);
        check_int("ind_press_ch0", ev_press[0], 6);
        check_int("ind_press_ch2", ev_press[2], 6);
        check_int("ind_rel_ch2", ev_rel[2], 16);
        check_int("ind_long_ch0", ev_long[0], 26);
        check_int("ind_rpt_ch0_first", ev_rpt[0], 31);
        check_int("ind_rpt_ch0_n", n_rpt[0], 5);

        // Random bouncy stimulus; slower channels get long holds.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, (3 << c)) == 0) btn_raw[c] = ~btn_raw[c];
                if ($urandom_range(0, 40) == 0) repeat_en[c] = ~repeat_en[c];
            end
            step();
            if (i == 700) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
